// File: rtl/x_mem_ctrl.sv
// x_mem_ctrl: memory/peripheral controller behind the RV32I core's memory port.
// Decodes each request to on-chip word RAM, a GPIO output register or a
// free-running cycle counter, with WAIT_CYCLES programmable wait states.
// Optional build macro X_MEM_CTRL_ERR_EN adds a sticky access-error flag (o_err)
// readable at 0x8000_0008 and cleared by any write there.
module x_mem_ctrl #(
  parameter int unsigned RAM_DEPTH   = 1024,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned GPIO_W      = 8,
  parameter string       INIT_FILE   = ""
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_valid,
  input  logic              i_rnw,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_data,
  output logic              o_accept,
  output logic [31:0]       o_data,
  output logic [GPIO_W-1:0] o_gpio
`ifdef X_MEM_CTRL_ERR_EN
  ,
  output logic              o_err
`endif
);

  localparam int unsigned AW = $clog2(RAM_DEPTH);

  // Word addresses (byte address >> 2) of the peripheral registers
  localparam logic [29:0] WA_GPIO = 30'h2000_0000;
  localparam logic [29:0] WA_CNT  = 30'h2000_0001;
  localparam logic [29:0] WA_ERR  = 30'h2000_0002;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_q;
  logic        rnw_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] rdata_q;
  logic [31:0] cyc_q;
  logic [31:0] rd_mux;
  logic        capture;
  logic        commit;
  logic        q_gpio, q_cnt, q_err, q_unmapped;
  logic        unused_addr_bits;

  logic [31:0] ram [RAM_DEPTH];

  assign unused_addr_bits = ^{i_addr[1:0], addr_q[1:0]};

  // Decode of the captured request, used at commit time
  always_comb begin
    q_gpio     = addr_q[31] && (addr_q[31:2] == WA_GPIO);
    q_cnt      = addr_q[31] && (addr_q[31:2] == WA_CNT);
`ifdef X_MEM_CTRL_ERR_EN
    q_err      = addr_q[31] && (addr_q[31:2] == WA_ERR);
`else
    q_err      = 1'b0;
`endif
    q_unmapped = addr_q[31] && !q_gpio && !q_cnt && !q_err;
  end

  // Read-data selection for the incoming request address
  always_comb begin
    rd_mux = '0;
    if (!i_addr[31]) begin
      rd_mux = ram[i_addr[AW+1:2]];
    end else if (i_addr[31:2] == WA_GPIO) begin
      rd_mux[GPIO_W-1:0] = o_gpio;
    end else if (i_addr[31:2] == WA_CNT) begin
      rd_mux = cyc_q;
`ifdef X_MEM_CTRL_ERR_EN
    end else if (i_addr[31:2] == WA_ERR) begin
      rd_mux[0] = o_err;
`endif
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic; a dropped valid during WAIT aborts the request
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (i_valid) state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: begin
        if (!i_valid)         state_d = S_IDLE;
        else if (wait_q == 1) state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: capture strobe, accept pulse and write commit
  always_comb begin
    capture  = (state_q == S_IDLE) && i_valid;
    o_accept = (state_q == S_RESP);
    commit   = (state_q == S_RESP) && !rnw_q;
  end

  // Request capture, wait counter and response data
  // o_data only moves on entry to RESP, so it holds between responses.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wait_q  <= '0;
      rnw_q   <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      o_data  <= '0;
    end else begin
      if (capture) begin
        rnw_q   <= i_rnw;
        addr_q  <= i_addr;
        data_q  <= i_data;
        rdata_q <= rd_mux;
        wait_q  <= 4'(WAIT_CYCLES);
      end else if (state_q == S_WAIT) begin
        wait_q <= wait_q - 4'd1;
      end
      if (state_d == S_RESP && state_q != S_RESP)
        o_data <= (state_q == S_IDLE) ? rd_mux : rdata_q;
    end
  end

  // Free-running cycle counter
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) cyc_q <= '0;
    else         cyc_q <= cyc_q + 32'd1;
  end

  // GPIO output register, written on the RESP edge
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)              o_gpio <= '0;
    else if (commit && q_gpio) o_gpio <= data_q[GPIO_W-1:0];
  end

  // RAM write port (contents are not reset)
  always_ff @(posedge i_clk) begin
    if (commit && !addr_q[31]) ram[addr_q[AW+1:2]] <= data_q;
  end

`ifdef X_MEM_CTRL_ERR_EN
  // Sticky error flag; a new error takes priority over a clear
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_err <= 1'b0;
    end else if (state_q == S_RESP && (q_unmapped || (!rnw_q && q_cnt))) begin
      o_err <= 1'b1;
    end else if (commit && q_err) begin
      o_err <= 1'b0;
    end
  end
`else
  logic unused_unmapped;
  assign unused_unmapped = q_unmapped;
`endif

endmodule
